// File: rtl/axi4lite_regbank.sv
// axi4lite_regbank: AXI4-lite slave holding NREG byte-strobed control
// registers, exposed in parallel on o_reg_out. Write channel collects AW and W
// independently, commits one edge after both are held, then holds the B
// response. Read channel snapshots the register at AR acceptance and presents
// it one edge later. Registers are cleared by i_reset only; i_aresetn low
// resets handshake state while keeping register contents.
// Optional feature macro: AXI4LITE_REGBANK_WPULSE_EN adds o_wr_pulse, a
// one-cycle per-register strobe aligned with the cycle the new value appears.
module axi4lite_regbank #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 32,
  parameter int NREG   = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_aresetn,
  input  logic [AWIDTH-1:0]      i_araddr,
  input  logic                   i_arvalid,
  output logic                   o_arready,
  output logic [DWIDTH-1:0]      o_rdata,
  output logic [1:0]             o_rresp,
  output logic                   o_rvalid,
  input  logic                   i_rready,
  input  logic [AWIDTH-1:0]      i_awaddr,
  input  logic                   i_awvalid,
  output logic                   o_awready,
  input  logic [DWIDTH-1:0]      i_wdata,
  input  logic [DWIDTH/8-1:0]    i_wstrb,
  input  logic                   i_wvalid,
  output logic                   o_wready,
  output logic [1:0]             o_bresp,
  output logic                   o_bvalid,
  input  logic                   i_bready,
  output logic [NREG*DWIDTH-1:0] o_reg_out
`ifdef AXI4LITE_REGBANK_WPULSE_EN
  ,
  output logic [NREG-1:0]        o_wr_pulse
`endif
);

  localparam int NB = DWIDTH / 8;
  localparam int IW = AWIDTH - 2;
  localparam logic [IW:0] LP_NREG = (IW + 1)'(NREG);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wState_t;
  typedef enum logic {R_IDLE, R_DATA} rState_t;

  logic [DWIDTH-1:0] r_regs [NREG];

  wState_t           r_wState;
  wState_t           w_wStateNext;
  logic              r_awCap;
  logic [IW-1:0]     r_awIdx;
  logic              r_wCap;
  logic [DWIDTH-1:0] r_wData;
  logic [NB-1:0]     r_wStrb;
  logic              r_awready;
  logic              r_wready;
  logic              r_bvalid;
  logic [1:0]        r_bresp;

  rState_t           r_rState;
  rState_t           w_rStateNext;
  logic              r_arCap;
  logic [DWIDTH-1:0] r_rdPend;
  logic [1:0]        r_rrespPend;
  logic              r_arready;
  logic              r_rvalid;
  logic [DWIDTH-1:0] r_rdata;
  logic [1:0]        r_rresp;

  logic              w_hsReset;
  logic              w_awHs;
  logic              w_wHs;
  logic              w_arHs;
  logic              w_commit;
  logic              w_awInRange;
  logic              w_awCapNext;
  logic              w_wCapNext;
  logic [IW-1:0]     w_arIdx;
  logic              w_arInRange;
  logic [DWIDTH-1:0] w_arData;
  logic              w_unusedAddrBits;

  assign w_hsReset   = i_reset | ~i_aresetn;
  assign w_awHs      = r_awready & i_awvalid;
  assign w_wHs       = r_wready & i_wvalid;
  assign w_arHs      = r_arready & i_arvalid;
  assign w_commit    = (r_wState == W_IDLE) & r_awCap & r_wCap & ~w_hsReset;
  assign w_awInRange = ({1'b0, r_awIdx} < LP_NREG);
  assign w_awCapNext = (r_awCap | w_awHs) & ~w_commit;
  assign w_wCapNext  = (r_wCap | w_wHs) & ~w_commit;
  assign w_arIdx     = i_araddr[AWIDTH-1:2];
  assign w_arInRange = ({1'b0, w_arIdx} < LP_NREG);
  assign w_unusedAddrBits = ^{i_araddr[1:0], i_awaddr[1:0]};

  assign o_awready = r_awready;
  assign o_wready  = r_wready;
  assign o_bvalid  = r_bvalid;
  assign o_bresp   = r_bresp;
  assign o_arready = r_arready;
  assign o_rvalid  = r_rvalid;
  assign o_rdata   = r_rdata;
  assign o_rresp   = r_rresp;

  // Register storage: cleared by full reset, byte-merged on an in-range commit
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_commit && w_awInRange) begin
      for (int i = 0; i < NREG; i++) begin
        if (r_awIdx == IW'(i)) begin
          for (int b = 0; b < NB; b++) begin
            if (r_wStrb[b]) r_regs[i][b*8 +: 8] <= r_wData[b*8 +: 8];
          end
        end
      end
    end
  end

  // Flatten the register array onto the parallel fabric output
  always_comb begin
    o_reg_out = '0;
    for (int i = 0; i < NREG; i++) o_reg_out[i*DWIDTH +: DWIDTH] = r_regs[i];
  end

  // Write FSM state register
  always_ff @(posedge i_clk) begin
    if (w_hsReset) r_wState <= W_IDLE;
    else           r_wState <= w_wStateNext;
  end

  // Write FSM next state: commit once both halves are held, leave on B handshake
  always_comb begin
    w_wStateNext = r_wState;
    case (r_wState)
      W_IDLE:  if (r_awCap && r_wCap) w_wStateNext = W_RESP;
      W_RESP:  if (r_bvalid && i_bready) w_wStateNext = W_IDLE;
      default: w_wStateNext = W_IDLE;
    endcase
  end

  // Hold whichever of AW/W has been accepted until the commit consumes both
  always_ff @(posedge i_clk) begin
    if (w_hsReset) begin
      r_awCap <= 1'b0;
      r_wCap  <= 1'b0;
      r_awIdx <= '0;
      r_wData <= '0;
      r_wStrb <= '0;
    end else if (w_commit) begin
      r_awCap <= 1'b0;
      r_wCap  <= 1'b0;
    end else begin
      if (w_awHs) begin
        r_awCap <= 1'b1;
        r_awIdx <= i_awaddr[AWIDTH-1:2];
      end
      if (w_wHs) begin
        r_wCap  <= 1'b1;
        r_wData <= i_wdata;
        r_wStrb <= i_wstrb;
      end
    end
  end

  // Write outputs: readies registered from next state, B response set on commit
  always_ff @(posedge i_clk) begin
    if (w_hsReset) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_awready <= (w_wStateNext == W_IDLE) & ~w_awCapNext;
      r_wready  <= (w_wStateNext == W_IDLE) & ~w_wCapNext;
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_awInRange ? RESP_OKAY : RESP_SLVERR;
      end else if (r_bvalid && i_bready) begin
        r_bvalid <= 1'b0;
        r_bresp  <= RESP_OKAY;
      end
    end
  end

`ifdef AXI4LITE_REGBANK_WPULSE_EN
  logic [NREG-1:0] r_wrPulse;

  // One-cycle strobe for the register being committed, aligned with bvalid rising
  always_ff @(posedge i_clk) begin
    if (w_hsReset) begin
      r_wrPulse <= '0;
    end else begin
      r_wrPulse <= '0;
      if (w_commit && w_awInRange) begin
        for (int i = 0; i < NREG; i++) begin
          if (r_awIdx == IW'(i)) r_wrPulse[i] <= 1'b1;
        end
      end
    end
  end

  assign o_wr_pulse = r_wrPulse;
`endif

  // Read-side mux: value of the addressed register, zero when out of range
  always_comb begin
    w_arData = '0;
    for (int i = 0; i < NREG; i++) begin
      if (w_arIdx == IW'(i)) w_arData = r_regs[i];
    end
  end

  // Read FSM state register
  always_ff @(posedge i_clk) begin
    if (w_hsReset) r_rState <= R_IDLE;
    else           r_rState <= w_rStateNext;
  end

  // Read FSM next state: present data after a snapshot, return on R handshake
  always_comb begin
    w_rStateNext = r_rState;
    case (r_rState)
      R_IDLE:  if (r_arCap) w_rStateNext = R_DATA;
      R_DATA:  if (r_rvalid && i_rready) w_rStateNext = R_IDLE;
      default: w_rStateNext = R_IDLE;
    endcase
  end

  // Snapshot data at AR acceptance so a same-edge write is not observed
  always_ff @(posedge i_clk) begin
    if (w_hsReset) begin
      r_arCap     <= 1'b0;
      r_rdPend    <= '0;
      r_rrespPend <= RESP_OKAY;
    end else if (r_arCap) begin
      r_arCap <= 1'b0;
    end else if (w_arHs) begin
      r_arCap     <= 1'b1;
      r_rdPend    <= w_arData;
      r_rrespPend <= w_arInRange ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Read outputs: arready from next state, R channel loaded from the snapshot
  always_ff @(posedge i_clk) begin
    if (w_hsReset) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_arready <= (w_rStateNext == R_IDLE) & ~w_arHs;
      if (r_arCap) begin
        r_rvalid <= 1'b1;
        r_rdata  <= r_rdPend;
        r_rresp  <= r_rrespPend;
      end else if (r_rvalid && i_rready) begin
        r_rvalid <= 1'b0;
        r_rdata  <= '0;
        r_rresp  <= RESP_OKAY;
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_regbank.sv
// tb_axi4lite_regbank: self-checking bench for axi4lite_regbank with a
// transaction-level register model. Covers AXI4LITE_REGBANK_WPULSE_EN when
// that macro is defined for both files.
module tb_axi4lite_regbank;

  localparam int AWIDTH = 12;
  localparam int DWIDTH = 32;
  localparam int NREG   = 16;

  logic                   i_clk = 1'b0;
  logic                   i_reset;
  logic                   i_aresetn;
  logic [AWIDTH-1:0]      i_araddr;
  logic                   i_arvalid;
  logic                   o_arready;
  logic [DWIDTH-1:0]      o_rdata;
  logic [1:0]             o_rresp;
  logic                   o_rvalid;
  logic                   i_rready;
  logic [AWIDTH-1:0]      i_awaddr;
  logic                   i_awvalid;
  logic                   o_awready;
  logic [DWIDTH-1:0]      i_wdata;
  logic [DWIDTH/8-1:0]    i_wstrb;
  logic                   i_wvalid;
  logic                   o_wready;
  logic [1:0]             o_bresp;
  logic                   o_bvalid;
  logic                   i_bready;
  logic [NREG*DWIDTH-1:0] o_reg_out;
`ifdef AXI4LITE_REGBANK_WPULSE_EN
  logic [NREG-1:0]        o_wr_pulse;
`endif

  int checkCount = 0;
  int failCount  = 0;
  logic [DWIDTH-1:0] modelRegs [NREG];

  axi4lite_regbank #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .NREG(NREG)) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_aresetn(i_aresetn),
    .i_araddr(i_araddr),
    .i_arvalid(i_arvalid),
    .o_arready(o_arready),
    .o_rdata(o_rdata),
    .o_rresp(o_rresp),
    .o_rvalid(o_rvalid),
    .i_rready(i_rready),
    .i_awaddr(i_awaddr),
    .i_awvalid(i_awvalid),
    .o_awready(o_awready),
    .i_wdata(i_wdata),
    .i_wstrb(i_wstrb),
    .i_wvalid(i_wvalid),
    .o_wready(o_wready),
    .o_bresp(o_bresp),
    .o_bvalid(o_bvalid),
    .i_bready(i_bready),
    .o_reg_out(o_reg_out)
`ifdef AXI4LITE_REGBANK_WPULSE_EN
    ,
    .o_wr_pulse(o_wr_pulse)
`endif
  );

  // Free-running clock
  always #5 i_clk = ~i_clk;

  // Hard stop in case a handshake never completes
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [NREG*DWIDTH-1:0] expRegOut();
    logic [NREG*DWIDTH-1:0] v;
    for (int i = 0; i < NREG; i++) v[i*DWIDTH +: DWIDTH] = modelRegs[i];
    return v;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < NREG; i++) modelRegs[i] = '0;
  endtask

  // Full write transaction with independent AW/W start delays and B backpressure
  task automatic axiWrite(input logic [AWIDTH-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int awDelay, input int wDelay, input int bDelay);
    bit awDone, wDone, awHsNow, wHsNow, inRange;
    int cyc, idx;
    logic [1:0] expResp;
    logic [NREG-1:0] expPulse;
    idx = int'(addr >> 2);
    inRange = (idx < NREG);
    expResp = inRange ? 2'b00 : 2'b10;
    expPulse = inRange ? (NREG'(1) << idx) : '0;
    awDone = 0; wDone = 0; cyc = 0;
    i_awaddr = addr; i_wdata = data; i_wstrb = strb;
    while (!(awDone && wDone) && cyc < 64) begin
      i_awvalid = !awDone && (cyc >= awDelay);
      i_wvalid  = !wDone && (cyc >= wDelay);
      @(negedge i_clk);
      awHsNow = i_awvalid && o_awready;
      wHsNow  = i_wvalid && o_wready;
      @(posedge i_clk); #1;
      if (awHsNow) awDone = 1;
      if (wHsNow) wDone = 1;
      if (awDone != wDone) begin
        checkOutput("partial_readies", {o_awready, o_wready}, {!awDone, !wDone});
        checkOutput("partial_no_bvalid", o_bvalid, 1'b0);
      end
      cyc++;
    end
    i_awvalid = 0; i_wvalid = 0;
    if (!(awDone && wDone)) begin
      checkOutput("write_timeout", 1'b0, 1'b1);
      return;
    end
    checkOutput("pre_commit_bvalid", o_bvalid, 1'b0);
    checkOutput("pre_commit_readies", {o_awready, o_wready}, 2'b00);
    if (inRange)
      for (int b = 0; b < 4; b++)
        if (strb[b]) modelRegs[idx][b*8 +: 8] = data[b*8 +: 8];
    @(posedge i_clk); #1;
    checkOutput("bvalid_rise", o_bvalid, 1'b1);
    checkOutput("bresp", o_bresp, expResp);
    checkOutput("reg_out_after_write", o_reg_out, expRegOut());
`ifdef AXI4LITE_REGBANK_WPULSE_EN
    checkOutput("wr_pulse_on", o_wr_pulse, expPulse);
`endif
    for (int k = 0; k < bDelay; k++) begin
      @(posedge i_clk); #1;
      checkOutput("bvalid_hold", {o_bvalid, o_bresp}, {1'b1, expResp});
      checkOutput("bp_readies_low", {o_awready, o_wready}, 2'b00);
`ifdef AXI4LITE_REGBANK_WPULSE_EN
      checkOutput("wr_pulse_hold_off", o_wr_pulse, '0);
`endif
    end
    i_bready = 1;
    @(posedge i_clk); #1;
    i_bready = 0;
    checkOutput("bvalid_drop", o_bvalid, 1'b0);
    checkOutput("write_readies_back", {o_awready, o_wready}, 2'b11);
`ifdef AXI4LITE_REGBANK_WPULSE_EN
    checkOutput("wr_pulse_off", o_wr_pulse, '0);
`endif
  endtask

  // Full read transaction with R backpressure; expectation taken from the model at AR time
  task automatic axiRead(input logic [AWIDTH-1:0] addr, input int rDelay);
    int idx;
    logic [31:0] expData;
    logic [1:0] expResp;
    idx = int'(addr >> 2);
    if (idx < NREG) begin expData = modelRegs[idx]; expResp = 2'b00; end
    else begin expData = '0; expResp = 2'b10; end
    i_araddr = addr; i_arvalid = 1;
    @(negedge i_clk);
    checkOutput("arready_idle", o_arready, 1'b1);
    @(posedge i_clk); #1;
    i_arvalid = 0;
    checkOutput("rvalid_not_yet", o_rvalid, 1'b0);
    checkOutput("arready_after_hs", o_arready, 1'b0);
    @(posedge i_clk); #1;
    checkOutput("rvalid_rise", o_rvalid, 1'b1);
    checkOutput("rdata", o_rdata, expData);
    checkOutput("rresp", o_rresp, expResp);
    for (int k = 0; k < rDelay; k++) begin
      @(posedge i_clk); #1;
      checkOutput("r_hold", {o_rvalid, o_rresp, o_rdata}, {1'b1, expResp, expData});
      checkOutput("bp_arready_low", o_arready, 1'b0);
    end
    i_rready = 1;
    @(posedge i_clk); #1;
    i_rready = 0;
    checkOutput("r_drop", {o_rvalid, o_rdata}, {1'b0, 32'h0});
    checkOutput("arready_back", o_arready, 1'b1);
  endtask

  // Randomized mix of reads and writes, including out-of-range indices
  task automatic applyStimulus(input int count);
    logic [AWIDTH-1:0] addr;
    for (int n = 0; n < count; n++) begin
      addr = AWIDTH'(($urandom_range(0, 19) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0)
        axiWrite(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2));
      else
        axiRead(addr, $urandom_range(0, 2));
    end
  endtask

  initial begin
    i_reset = 1; i_aresetn = 1;
    i_araddr = '0; i_arvalid = 0; i_rready = 0;
    i_awaddr = '0; i_awvalid = 0; i_wdata = '0; i_wstrb = '0; i_wvalid = 0; i_bready = 0;
    clearModel();
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("reset_readies", {o_awready, o_wready, o_arready}, 3'b000);
    checkOutput("reset_valids", {o_bvalid, o_rvalid, o_bresp, o_rresp}, 6'b0);
    checkOutput("reset_rdata", o_rdata, 32'h0);
    checkOutput("reset_reg_out", o_reg_out, '0);
    i_reset = 0;
    @(posedge i_clk); #1;
    checkOutput("readies_after_reset", {o_awready, o_wready, o_arready}, 3'b111);

    $display("[TB] basic write/read");
    axiWrite(12'h004, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    checkOutput("reg1_deadbeef", o_reg_out[63:32], 32'hDEADBEEF);
    axiRead(12'h004, 0);

    $display("[TB] W before AW with partial strobe");
    axiWrite(12'h008, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    axiWrite(12'h008, 32'h12345678, 4'h5, 3, 0, 0);
    checkOutput("reg2_merge", o_reg_out[95:64], 32'hFF34FF78);

    $display("[TB] out of range");
    axiWrite(12'h040, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
    axiRead(12'h040, 0);

    $display("[TB] backpressure");
    axiWrite(12'h00C, 32'hCAFEF00D, 4'hF, 0, 0, 10);
    axiRead(12'h00C, 10);

    $display("[TB] zero strobe");
    axiWrite(12'h004, 32'h00000000, 4'h0, 1, 0, 0);
    checkOutput("wstrb0_unchanged", o_reg_out[63:32], 32'hDEADBEEF);

    $display("[TB] same-cycle read and write commit");
    axiWrite(12'h000, 32'h00000001, 4'hF, 0, 0, 0);
    i_awaddr = 12'h000; i_wdata = 32'h2; i_wstrb = 4'hF;
    i_awvalid = 1; i_wvalid = 1;
    @(posedge i_clk); #1;
    i_awvalid = 0; i_wvalid = 0;
    i_araddr = 12'h000; i_arvalid = 1;
    @(posedge i_clk); #1;
    i_arvalid = 0;
    modelRegs[0] = 32'h2;
    checkOutput("same_bvalid", o_bvalid, 1'b1);
    checkOutput("same_reg0_new", o_reg_out[31:0], 32'h2);
    checkOutput("same_arready_low", o_arready, 1'b0);
`ifdef AXI4LITE_REGBANK_WPULSE_EN
    checkOutput("same_wr_pulse", o_wr_pulse, 16'h0001);
`endif
    @(posedge i_clk); #1;
    checkOutput("same_rvalid", o_rvalid, 1'b1);
    checkOutput("same_read_old", o_rdata, 32'h1);
`ifdef AXI4LITE_REGBANK_WPULSE_EN
    checkOutput("same_wr_pulse_off", o_wr_pulse, '0);
`endif
    i_bready = 1; i_rready = 1;
    @(posedge i_clk); #1;
    i_bready = 0; i_rready = 0;
    checkOutput("same_drain", {o_bvalid, o_rvalid}, 2'b00);
    axiRead(12'h000, 0);

    $display("[TB] reset with AW captured");
    i_awaddr = 12'h010; i_awvalid = 1;
    @(posedge i_clk); #1;
    i_awvalid = 0;
    checkOutput("aw_captured", {o_awready, o_wready}, 2'b01);
    i_reset = 1;
    @(posedge i_clk); #1;
    clearModel();
    checkOutput("midreset_readies", {o_awready, o_wready, o_arready}, 3'b000);
    checkOutput("midreset_reg_out", o_reg_out, '0);
    i_reset = 0;
    @(posedge i_clk); #1;
    checkOutput("release_readies", {o_awready, o_wready, o_arready}, 3'b111);
    repeat (3) begin
      @(posedge i_clk); #1;
      checkOutput("no_stale_bvalid", o_bvalid, 1'b0);
    end

    $display("[TB] aresetn with W captured");
    axiWrite(12'h014, 32'h5555AAAA, 4'hF, 0, 0, 0);
    i_wdata = 32'h11111111; i_wstrb = 4'hF; i_wvalid = 1;
    @(posedge i_clk); #1;
    i_wvalid = 0;
    i_aresetn = 0;
    @(posedge i_clk); #1;
    checkOutput("aresetn_readies", {o_awready, o_wready, o_arready}, 3'b000);
    checkOutput("aresetn_reg_out", o_reg_out, expRegOut());
    i_aresetn = 1;
    @(posedge i_clk); #1;
    checkOutput("aresetn_release_readies", {o_awready, o_wready, o_arready}, 3'b111);
    checkOutput("aresetn_no_bvalid", o_bvalid, 1'b0);
    axiWrite(12'h018, 32'h87654321, 4'hF, 2, 0, 0);
    axiRead(12'h014, 0);

    $display("[TB] randomized traffic");
    applyStimulus(60);
    @(negedge i_clk);
    checkOutput("final_reg_out", o_reg_out, expRegOut());

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
